// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequence/decode unit: Moore FSM driving all datapath control and SRAM strobes.
// Optional PAUSE instruction (opcode 1101) is built when SLC3_PAUSE_EN is defined.
module slc3_isdu #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    input  logic       Run,
    input  logic       Continue,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_BEN,
    output logic       LD_CC,
    output logic       LD_REG,
    output logic       LD_PC,
    output logic       LD_LED,
    output logic       GatePC,
    output logic       GateMDR,
    output logic       GateALU,
    output logic       GateMARMUX,
    output logic [1:0] PCMUX,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_OE,
    output logic       Mem_WE
);

    typedef enum logic [4:0] {
        HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12,
        S04, S21, S20, S06, S25, S27, S07, S23, S16
`ifdef SLC3_PAUSE_EN
        , PAUSE1, PAUSE2
`endif
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mem_last;

`ifdef SLC3_PAUSE_EN
    logic led_first_q, led_first_d;
`else
    logic unused_continue;
    assign unused_continue = Continue;
`endif

    assign mem_last = (cnt_q == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HALTED;
            cnt_q       <= 4'd0;
`ifdef SLC3_PAUSE_EN
            led_first_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
`ifdef SLC3_PAUSE_EN
            led_first_q <= led_first_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        LD_LED     = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;

        unique case (state_q)
            HALTED: if (Run) state_d = S18;
            S18: begin
                GatePC  = 1'b1;
                LD_MAR  = 1'b1;
                LD_PC   = 1'b1;
                state_d = S33;
                cnt_d   = WAIT_LD;
            end
            // SRAM read: counter holds the state, MDR captures on the last cycle
            S33, S25: begin
                Mem_OE = 1'b0;
                LD_MDR = mem_last;
                if (mem_last) state_d = (state_q == S33) ? S35 : S27;
                else          cnt_d   = cnt_q - 4'd1;
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
                state_d = S32;
            end
            S32: begin
                LD_BEN = 1'b1;
                unique case (Opcode)
                    4'b0001: state_d = S01;
                    4'b0101: state_d = S05;
                    4'b1001: state_d = S09;
                    4'b0000: state_d = S00;
                    4'b1100: state_d = S12;
                    4'b0100: state_d = S04;
                    4'b0110: state_d = S06;
                    4'b0111: state_d = S07;
`ifdef SLC3_PAUSE_EN
                    4'b1101: state_d = PAUSE1;
`endif
                    default: state_d = S18;
                endcase
            end
            S01, S05, S09: begin
                SR1MUX  = 1'b1;
                SR2MUX  = (state_q != S09) ? IR_5 : 1'b0;
                ALUK    = (state_q == S01) ? 2'b00 : (state_q == S05) ? 2'b01 : 2'b10;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S18;
            end
            S00: state_d = BEN ? S22 : S18;
            S22: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = S18;
            end
            S12, S20: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = S18;
            end
            S04: begin
                GatePC  = 1'b1;
                DRMUX   = 1'b1;
                LD_REG  = 1'b1;
                state_d = IR_11 ? S21 : S20;
            end
            S21: begin
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
                state_d  = S18;
            end
            S06, S07: begin
                SR1MUX     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                state_d    = (state_q == S06) ? S25 : S23;
                cnt_d      = WAIT_LD;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                state_d = S18;
            end
            S23: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
                state_d = S16;
                cnt_d   = WAIT_LD;
            end
            S16: begin
                Mem_WE = 1'b0;
                if (mem_last) state_d = S18;
                else          cnt_d   = cnt_q - 4'd1;
            end
`ifdef SLC3_PAUSE_EN
            // Continue must be pressed and released before fetching again
            PAUSE1: begin
                LD_LED = led_first_q;
                if (Continue) state_d = PAUSE2;
            end
            PAUSE2: if (!Continue) state_d = S18;
`endif
            default: state_d = HALTED;
        endcase
    end

`ifdef SLC3_PAUSE_EN
    assign led_first_d = (state_d == PAUSE1) && (state_q != PAUSE1);
`endif

endmodule

// File: tb/tb_slc3_isdu.sv
// Directed bench for slc3_isdu: table of single-instruction runs plus reset, STR (W=3) and PAUSE sequences.
module tb_slc3_isdu;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Opcode = 4'd0;
    logic       IR_5 = 1'b0, IR_11 = 1'b0, BEN = 1'b0, Run = 1'b0, Continue = 1'b0;
    logic [23:0] o2, o3;
    logic [23:0] trace [0:63];
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    slc3_isdu #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .Run(Run), .Continue(Continue),
        .LD_MAR(o2[23]), .LD_MDR(o2[22]), .LD_IR(o2[21]), .LD_BEN(o2[20]), .LD_CC(o2[19]),
        .LD_REG(o2[18]), .LD_PC(o2[17]), .LD_LED(o2[16]), .GatePC(o2[15]), .GateMDR(o2[14]),
        .GateALU(o2[13]), .GateMARMUX(o2[12]), .PCMUX(o2[11:10]), .DRMUX(o2[9]), .SR1MUX(o2[8]),
        .SR2MUX(o2[7]), .ADDR1MUX(o2[6]), .ADDR2MUX(o2[5:4]), .ALUK(o2[3:2]), .Mem_OE(o2[1]),
        .Mem_WE(o2[0]));

    slc3_isdu #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .reset(reset), .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
        .Run(Run), .Continue(Continue),
        .LD_MAR(o3[23]), .LD_MDR(o3[22]), .LD_IR(o3[21]), .LD_BEN(o3[20]), .LD_CC(o3[19]),
        .LD_REG(o3[18]), .LD_PC(o3[17]), .LD_LED(o3[16]), .GatePC(o3[15]), .GateMDR(o3[14]),
        .GateALU(o3[13]), .GateMARMUX(o3[12]), .PCMUX(o3[11:10]), .DRMUX(o3[9]), .SR1MUX(o3[8]),
        .SR2MUX(o3[7]), .ADDR1MUX(o3[6]), .ADDR2MUX(o3[5:4]), .ALUK(o3[3:2]), .Mem_OE(o3[1]),
        .Mem_WE(o3[0]));

    // loads {MAR,MDR,IR,BEN,CC,REG,PC,LED}, gates {PC,MDR,ALU,MARMUX}
    function automatic logic [23:0] ctl(logic [7:0] ld, logic [3:0] g, logic [1:0] pcm, logic dr,
                                        logic sr1, logic sr2, logic a1, logic [1:0] a2,
                                        logic [1:0] alu, logic oe, logic we);
        return {ld, g, pcm, dr, sr1, sr2, a1, a2, alu, oe, we};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One instruction from reset: trace[1] is the HALTED cycle with Run high; len is the
    // last cycle before the second S18 (0 if that never arrives in the budget).
    task automatic run_prog(input bit use3, input logic [3:0] opc, input logic i5, input logic i11,
                            input logic b, output int len);
        logic [23:0] cur;
        bit seen;
        reset = 1'b0; Run = 1'b0; Continue = 1'b0;
        Opcode = opc; IR_5 = i5; IR_11 = i11; BEN = b;
        @(negedge clk);
        reset = 1'b1; Run = 1'b1;
        trace[1] = use3 ? o3 : o2;
        seen = 1'b0;
        len = 0;
        for (int c = 2; c < 64; c++) begin
            @(negedge clk);
            Run = 1'b0;
            cur = use3 ? o3 : o2;
            trace[c] = cur;
            if (cur[23] && cur[15] && cur[17]) begin
                if (seen) begin
                    len = c - 1;
                    break;
                end
                seen = 1'b1;
            end
        end
    endtask

    typedef struct {
        string      name;
        logic [3:0] opc;
        logic       i5, i11, b;
        int         len;
        logic [23:0] last;
        int         oe, we;
    } vec_t;

    initial begin
        vec_t vecs[$];
        logic [23:0] DEF, S18C;
        int len, oe_n, we_n, ovl, led_n, first_ir;

        DEF  = ctl(8'h00, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        S18C = ctl(8'h82, 4'b1000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1);

        vecs.push_back('{"add",    4'b0001, 1, 0, 0, 7,  ctl(8'h0C, 4'b0010, 2'b00, 0, 1, 1, 0, 2'b00, 2'b00, 1, 1), 2, 0});
        vecs.push_back('{"and",    4'b0101, 0, 0, 0, 7,  ctl(8'h0C, 4'b0010, 2'b00, 0, 1, 0, 0, 2'b00, 2'b01, 1, 1), 2, 0});
        vecs.push_back('{"not",    4'b1001, 1, 0, 0, 7,  ctl(8'h0C, 4'b0010, 2'b00, 0, 1, 0, 0, 2'b00, 2'b10, 1, 1), 2, 0});
        vecs.push_back('{"br_nt",  4'b0000, 0, 0, 0, 7,  DEF, 2, 0});
        vecs.push_back('{"br_t",   4'b0000, 0, 0, 1, 8,  ctl(8'h02, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b10, 2'b00, 1, 1), 2, 0});
        vecs.push_back('{"jmp",    4'b1100, 0, 0, 0, 7,  ctl(8'h02, 4'b0000, 2'b10, 0, 1, 0, 1, 2'b00, 2'b00, 1, 1), 2, 0});
        vecs.push_back('{"jsr",    4'b0100, 0, 1, 0, 8,  ctl(8'h02, 4'b0000, 2'b10, 0, 0, 0, 0, 2'b11, 2'b00, 1, 1), 2, 0});
        vecs.push_back('{"jsrr",   4'b0100, 0, 0, 0, 8,  ctl(8'h02, 4'b0000, 2'b10, 0, 1, 0, 1, 2'b00, 2'b00, 1, 1), 2, 0});
        vecs.push_back('{"ldr",    4'b0110, 0, 0, 0, 10, ctl(8'h0C, 4'b0100, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1), 4, 0});
        vecs.push_back('{"str",    4'b0111, 0, 0, 0, 10, ctl(8'h00, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0), 2, 2});
        vecs.push_back('{"nop_f",  4'b1111, 0, 0, 1, 6,  ctl(8'h10, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1), 2, 0});
        vecs.push_back('{"nop_2",  4'b0010, 1, 1, 0, 6,  ctl(8'h10, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1), 2, 0});
`ifndef SLC3_PAUSE_EN
        vecs.push_back('{"pause_nop", 4'b1101, 0, 0, 0, 6, ctl(8'h10, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1), 2, 0});
`endif

        #1;
        chk("reset_def_w2", o2, DEF);
        chk("reset_def_w3", o3, DEF);

        foreach (vecs[i]) begin
            run_prog(0, vecs[i].opc, vecs[i].i5, vecs[i].i11, vecs[i].b, len);
            chk({vecs[i].name, "_len"}, len, vecs[i].len);
            if (len > 1) begin
                oe_n = 0; we_n = 0; ovl = 0; led_n = 0;
                for (int c = 1; c <= len; c++) begin
                    if (!trace[c][1]) oe_n++;
                    if (!trace[c][0]) we_n++;
                    if (!trace[c][1] && !trace[c][0]) ovl++;
                    if (trace[c][16]) led_n++;
                end
                chk({vecs[i].name, "_last"}, trace[len], vecs[i].last);
                chk({vecs[i].name, "_oe_low"}, oe_n, vecs[i].oe);
                chk({vecs[i].name, "_we_low"}, we_n, vecs[i].we);
                chk({vecs[i].name, "_oe_we_overlap"}, ovl, 0);
                chk({vecs[i].name, "_led"}, led_n, 0);
            end
        end

        // ADD detail: fetch timing and register write with immediate select
        run_prog(0, 4'b0001, 1, 0, 0, len);
        first_ir = 0;
        for (int c = 1; c < 64; c++) if (trace[c][21] && first_ir == 0) first_ir = c;
        chk("add_ld_ir_cycle", first_ir, 5);
        chk("add_oe_cycles", {trace[2][1], trace[3][1], trace[4][1], trace[5][1]}, 4'b1001);
        chk("add_s01_reg_cc_sr2", {trace[7][19], trace[7][18], trace[7][7]}, 3'b111);

        // JSR link step before the PC update
        run_prog(0, 4'b0100, 0, 1, 0, len);
        chk("jsr_s04", trace[7], ctl(8'h04, 4'b1000, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 1, 1));

        // STR with three-cycle memory
        run_prog(1, 4'b0111, 0, 0, 0, len);
        chk("str_w3_len", len, 12);
        chk("str_w3_s07", trace[8], ctl(8'h80, 4'b0001, 2'b00, 0, 1, 0, 1, 2'b01, 2'b00, 1, 1));
        chk("str_w3_s23", trace[9], ctl(8'h40, 4'b0010, 2'b00, 0, 0, 0, 0, 2'b00, 2'b11, 1, 1));
        chk("str_w3_we", {trace[9][0], trace[10][0], trace[11][0], trace[12][0]}, 4'b1000);

        // Reset asserted mid-read
        reset = 1'b0; Run = 1'b0; Opcode = 4'b0001;
        @(negedge clk);
        reset = 1'b1; Run = 1'b1;
        @(negedge clk);
        Run = 1'b0;
        @(negedge clk);
        chk("s33_oe_low", o2[1], 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_w2", o2, DEF);
        chk("async_reset_w3", o3, DEF);
        @(negedge clk);
        chk("reset_held_halted", o2, DEF);
        reset = 1'b1; Run = 1'b1;
        @(negedge clk);
        Run = 1'b0;
        chk("restart_s18", o2, S18C);

`ifdef SLC3_PAUSE_EN
        reset = 1'b0; Continue = 1'b0; Opcode = 4'b1101;
        @(negedge clk);
        reset = 1'b1; Run = 1'b1;
        for (int c = 2; c <= 7; c++) begin
            @(negedge clk);
            Run = 1'b0;
        end
        chk("pause1_led", o2, ctl(8'h01, 4'b0000, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1));
        @(negedge clk);
        chk("pause1_hold", o2, DEF);
        Continue = 1'b1;
        @(negedge clk);
        chk("pause2_enter", o2, DEF);
        @(negedge clk);
        chk("pause2_hold", o2, DEF);
        Continue = 1'b0;
        @(negedge clk);
        chk("pause_exit_s18", o2, S18C);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
